// File: rtl/oam_dma_ctrl.sv
// Sprite-memory DMA controller and CPU bus arbiter: a write to $4014 stalls the CPU and copies a page to OAM.
// Optional build macro OAMDMA_ALIGN_EN adds the parity ALIGN cycle (513/514-cycle stall instead of fixed 513).
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int unsigned XFER_LEN      = 256
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] CPU_ADDR,
   input  logic        CPU_WR,
   input  logic [7:0]  CPU_DO,
   input  logic [7:0]  BUS_DI,
   output logic        RDY,
   output logic [15:0] BUS_ADDR,
   output logic        BUS_WR,
   output logic [7:0]  BUS_DO,
   output logic        DMA_BUSY,
   output logic        DMA_DONE
);

   localparam int unsigned IDX_W = 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       page_q, page_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic [7:0]       data_q, data_d;
   logic             rdy_q, rdy_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef OAMDMA_ALIGN_EN
   logic             par_q;
`endif

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      index_d = index_q;
      data_d  = data_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!CPU_WR && (CPU_ADDR == DMA_REG_ADDR)) begin
               state_d = ST_HALT;
               page_d  = CPU_DO;
               index_d = '0;
            end
         end
         ST_HALT: begin
`ifdef OAMDMA_ALIGN_EN
            // Reads must land on even parity; an even HALT needs one extra dummy cycle.
            state_d = par_q ? ST_READ : ST_ALIGN;
`else
            state_d = ST_READ;
`endif
         end
`ifdef OAMDMA_ALIGN_EN
         ST_ALIGN: state_d = ST_READ;
`endif
         ST_READ: begin
            data_d  = BUS_DI;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (index_q == LAST_IDX) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               index_d = index_q + IDX_W'(1);
               state_d = ST_READ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rdy_d  = (state_d == ST_IDLE);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         page_q  <= '0;
         index_q <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef OAMDMA_ALIGN_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         index_q <= index_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef OAMDMA_ALIGN_EN
         par_q   <= ~par_q;
`endif
      end
   end

   // Bus arbitration: CPU passes straight through while idle, DMA drives otherwise
   always_comb begin
      BUS_ADDR = CPU_ADDR;
      BUS_WR   = CPU_WR;
      BUS_DO   = CPU_DO;
      case (state_q)
         ST_HALT, ST_ALIGN: begin
            BUS_ADDR = CPU_ADDR;
            BUS_WR   = 1'b1;
            BUS_DO   = data_q;
         end
         ST_READ: begin
            BUS_ADDR = {page_q, index_q};
            BUS_WR   = 1'b1;
            BUS_DO   = data_q;
         end
         ST_WRITE: begin
            BUS_ADDR = OAM_DATA_ADDR;
            BUS_WR   = 1'b0;
            BUS_DO   = data_q;
         end
         default: ;
      endcase
   end

   assign RDY      = rdy_q;
   assign DMA_BUSY = busy_q;
   assign DMA_DONE = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl; expectations follow OAMDMA_ALIGN_EN when defined.
module tb_oam_dma_ctrl;

`ifdef OAMDMA_ALIGN_EN
   localparam int ALIGN_EN = 1;
`else
   localparam int ALIGN_EN = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic        cpu_wr;
   logic [7:0]  cpu_do;
   logic [7:0]  bus_di;
   logic        rdy;
   logic [15:0] bus_addr;
   logic        bus_wr;
   logic [7:0]  bus_do;
   logic        busy;
   logic        done;

   logic [7:0]  mem [0:65535];
   int unsigned cyc;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   oam_dma_ctrl dut (
      .Clk      (clk),
      .Reset    (reset),
      .CPU_ADDR (cpu_addr),
      .CPU_WR   (cpu_wr),
      .CPU_DO   (cpu_do),
      .BUS_DI   (bus_di),
      .RDY      (rdy),
      .BUS_ADDR (bus_addr),
      .BUS_WR   (bus_wr),
      .BUS_DO   (bus_do),
      .DMA_BUSY (busy),
      .DMA_DONE (done)
   );

   assign bus_di = mem[bus_addr];

   // Cycles elapsed since reset was last released; its low bit is the expected bus parity
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_rom();
      return 16'h8000 | 16'($urandom_range(0, 32767));
   endfunction

   // Trigger one transfer from `page` (parity 0/1 forced, 2 = whatever comes) and check it end to end
   task automatic run_dma(input logic [7:0] page, input int want_par);
      int p, stall, first_rd, nrd, nwr, ndone, busy_err, next_pg, exp_stall;
      logic [15:0] last_rd;
      bit ended;
      next_cyc();
      while (want_par < 2 && int'(cyc % 2) != want_par) next_cyc();
      cpu_wr = 1'b0; cpu_addr = 16'h4014; cpu_do = page;
      p = int'(cyc % 2);
      #1;
      chk("trig_pass_addr", 32'(bus_addr), 32'h4014);
      chk("trig_pass_wr", 32'(bus_wr), 32'd0);
      @(negedge clk);
      chk("trig_rdy", 32'(rdy), 32'd1);
      stall = 0; first_rd = -1; nrd = 0; nwr = 0; ndone = 0; busy_err = 0; next_pg = 0;
      last_rd = '0; ended = 0;
      for (int t = 1; t < 1100; t++) begin
         next_cyc();
         cpu_wr = 1'b1; cpu_addr = rand_rom(); cpu_do = 8'($urandom);
         @(negedge clk);
         if (busy !== ~rdy) busy_err++;
         if (done) ndone++;
         if (t == 1) begin
            chk("halt_rdy", 32'(rdy), 32'd0);
            chk("halt_addr", 32'(bus_addr), 32'(cpu_addr));
            chk("halt_wr", 32'(bus_wr), 32'd1);
         end
         if (rdy) begin
            chk("done_on_release", 32'(done), 32'd1);
            ended = 1;
            break;
         end
         stall++;
         if (bus_addr != cpu_addr && bus_addr[15:8] == page + 8'd1) next_pg++;
         if (bus_wr && bus_addr != cpu_addr) begin
            if (first_rd < 0) first_rd = t;
            chk("read_addr", 32'(bus_addr), 32'({page, 8'(nrd)}));
            last_rd = bus_addr;
            nrd++;
         end else if (!bus_wr) begin
            chk("write_addr", 32'(bus_addr), 32'h2004);
            chk("write_data", 32'(bus_do), 32'(mem[{page, 8'(nwr)}]));
            nwr++;
         end
      end
      exp_stall = 513 + ((ALIGN_EN == 1 && p == 1) ? 1 : 0);
      chk("ended", 32'(ended), 32'd1);
      chk("stall_len", 32'(stall), 32'(exp_stall));
      chk("first_read", 32'(first_rd), 32'(2 + exp_stall - 513));
      chk("n_reads", 32'(nrd), 32'd256);
      chk("n_writes", 32'(nwr), 32'd256);
      chk("last_read", 32'(last_rd), 32'({page, 8'hFF}));
      chk("next_page_access", 32'(next_pg), 32'd0);
      chk("busy_vs_rdy", 32'(busy_err), 32'd0);
      chk("done_count", 32'(ndone), 32'd1);
   endtask

   initial begin
      int nwr, nwr_after, ndone_after;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;
      reset = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h8000; cpu_do = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rdy", 32'(rdy), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      next_cyc();
      reset = 1'b0;

      // Pass-through while idle, observed without any clock edge in between
      cpu_addr = 16'h8000; cpu_wr = 1'b1;
      #1;
      chk("pt_read_addr", 32'(bus_addr), 32'h8000);
      chk("pt_read_wr", 32'(bus_wr), 32'd1);
      cpu_addr = 16'h0010; cpu_wr = 1'b0; cpu_do = 8'h3C;
      #1;
      chk("pt_write_addr", 32'(bus_addr), 32'h0010);
      chk("pt_write_wr", 32'(bus_wr), 32'd0);
      chk("pt_write_do", 32'(bus_do), 32'h3C);
      next_cyc();
      cpu_wr = 1'b1; cpu_addr = 16'h8000;
      @(negedge clk);
      chk("pt_rdy", 32'(rdy), 32'd1);
      chk("pt_busy", 32'(busy), 32'd0);

      run_dma(8'h02, 0);
      run_dma(8'h02, 1);
      run_dma(8'h07, 2);
      run_dma(8'h03, 2);
      for (int k = 0; k < 2; k++) run_dma(8'($urandom_range(0, 126)), 2);

      // Reset after the 100th OAM write
      next_cyc();
      cpu_wr = 1'b0; cpu_addr = 16'h4014; cpu_do = 8'h02;
      nwr = 0;
      for (int t = 0; t < 400 && nwr < 100; t++) begin
         next_cyc();
         cpu_wr = 1'b1; cpu_addr = rand_rom();
         @(negedge clk);
         if (!bus_wr && bus_addr == 16'h2004) nwr++;
      end
      chk("mid_reached_100", 32'(nwr), 32'd100);
      next_cyc();
      reset = 1'b1;
      next_cyc();
      reset = 1'b0; cpu_addr = rand_rom();
      @(negedge clk);
      chk("mid_rdy", 32'(rdy), 32'd1);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_addr", 32'(bus_addr), 32'(cpu_addr));
      nwr_after = 0; ndone_after = 0;
      for (int t = 0; t < 600; t++) begin
         if (!bus_wr && bus_addr == 16'h2004) nwr_after++;
         if (done || !rdy) ndone_after++;
         next_cyc();
         cpu_addr = rand_rom();
         @(negedge clk);
      end
      chk("mid_no_writes", 32'(nwr_after), 32'd0);
      chk("mid_no_done", 32'(ndone_after), 32'd0);

      // Reset and trigger in the same cycle: reset wins
      next_cyc();
      reset = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h4014; cpu_do = 8'h05;
      next_cyc();
      reset = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'h8000;
      @(negedge clk);
      chk("rst_trig_rdy", 32'(rdy), 32'd1);
      chk("rst_trig_busy", 32'(busy), 32'd0);
      next_cyc();
      @(negedge clk);
      chk("rst_trig_rdy2", 32'(rdy), 32'd1);

      // A transfer still works after all that
      run_dma(8'h02, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
